// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a dual-read-port register file in pairs and streams
// each register's (address, value) over a valid/ready interface.
// Optional feature macro: DUMP_CHECKSUM_EN adds a running XOR of accepted beats.
module regfile_dumper #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [AW-1:0]   a1_o,
  output logic [AW-1:0]   a2_o,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [AW-1:0]   out_addr_o,
  output logic [XLEN-1:0] out_data_o
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [XLEN-1:0] checksum_o
`endif
);

  typedef enum logic [2:0] {StIdle, StRead, StSend0, StSend1, StDone} state_e;

  // Base of the final pair; avoids an AW-bit overflow when comparing ptr+2 to NREGS.
  localparam logic [AW-1:0] LastPtr = AW'(NREGS - 2);

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic [XLEN-1:0] buf1_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   a1_q;
  logic [AW-1:0]   a2_q;
  logic            valid_q;
  logic [AW-1:0]   addr_q;
  // data_q also serves as the even-register capture (buf0); only registered
  // values ever reach out_data, so there is no path from RD1/RD2 to the output.
  logic [XLEN-1:0] data_q;
`ifdef DUMP_CHECKSUM_EN
  logic [XLEN-1:0] checksum_q;
`endif

  // Dump sequencer: state, pair pointer, capture buffer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      buf1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef DUMP_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StRead;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            a1_q       <= '0;
            a2_q       <= AW'(1);
`ifdef DUMP_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        StRead: begin
          // Snapshot both registers of the pair on this edge.
          data_q  <= rd1_i;
          buf1_q  <= rd2_i;
          addr_q  <= ptr_q;
          valid_q <= 1'b1;
          a1_q    <= '0;
          a2_q    <= '0;
          state_q <= StSend0;
        end
        StSend0: begin
          if (out_ready_i) begin
            addr_q     <= ptr_q + AW'(1);
            data_q     <= buf1_q;
`ifdef DUMP_CHECKSUM_EN
            checksum_q <= checksum_q ^ data_q;
`endif
            state_q    <= StSend1;
          end
        end
        StSend1: begin
          if (out_ready_i) begin
            valid_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum_q <= checksum_q ^ data_q;
`endif
            if (ptr_q == LastPtr) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= ptr_q + AW'(2);
              a1_q    <= ptr_q + AW'(2);
              a2_q    <= ptr_q + AW'(3);
              state_q <= StRead;
            end
          end
        end
        // start is deliberately not sampled here.
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign a1_o        = a1_q;
  assign a2_o        = a2_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
`ifdef DUMP_CHECKSUM_EN
  assign checksum_o  = checksum_q;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: a register-file model drives RD1/RD2,
// expected beats are queued when a dump is started and popped on acceptance.
module tb_regfile_dumper;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic [XLEN-1:0] out_data;
`ifdef DUMP_CHECKSUM_EN
  logic [XLEN-1:0] checksum;
`endif

  logic [XLEN-1:0] regs [NR];
  logic [AW+XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] exp_ck;
  int tests = 0;
  int fails = 0;

  assign rd1 = regs[a1];
  assign rd2 = regs[a2];

  always #5 clk = ~clk;

  regfile_dumper #(.XLEN(XLEN), .AW(AW), .NREGS(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .a1_o        (a1),
    .a2_o        (a2),
    .rd1_i       (rd1),
    .rd2_i       (rd2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .out_data_o  (out_data)
`ifdef DUMP_CHECKSUM_EN
    ,
    .checksum_o  (checksum)
`endif
  );

  task automatic preload();
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[0] = 32'hAC;
    regs[1] = 32'hF0;
    regs[2] = 32'h0F;
    regs[3] = 32'hC3;
  endtask

  // Queue the full expected beat sequence from the current register contents.
  task automatic push_dump();
    exp_ck = '0;
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back({AW'(i), regs[i]});
      exp_ck = exp_ck ^ regs[i];
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the READ cycle.
  task automatic start_dump();
    @(negedge clk);
    start = 1'b1;
    push_dump();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one dump to completion, consuming the scoreboard.
  // ready_mode 0: ready always high; 1: ready high one cycle in three.
  // inject_at >= 0: pulse start while the beat with that index is presented.
  task automatic collect(input int ready_mode, input int inject_at, output int first_valid);
    int k = 0;
    int beats = 0;
    int last_acc = -10;
    int reads = 0;
    int exp_pair = 2;
    bit done_seen = 0;
    bit stalled = 0;
    bit injected = 0;
    logic [AW-1:0] held_addr;
    logic [XLEN-1:0] held_data;
    logic [AW+XLEN-1:0] e;
    first_valid = 0;
    while (k < 1000 && !done_seen) begin
      @(negedge clk);
      k++;
      if (inject_at >= 0) start = 1'b0;
      if (done) begin
        done_seen = 1;
        tests++;
        if (k != last_acc + 1) begin
          fails++;
          $display("FAIL done_timing: done at cycle %0d, required %0d", k, last_acc + 1);
        end
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL beats_left: %0d beats outstanding, required 0", exp_q.size());
        end
      end else if (busy && !out_valid) begin
        reads++;
        tests++;
        if (a1 !== AW'(exp_pair) || a2 !== AW'(exp_pair + 1)) begin
          fails++;
          $display("FAIL read_addr: A1=%0d A2=%0d, required %0d/%0d", a1, a2, exp_pair,
                   exp_pair + 1);
        end
        exp_pair += 2;
      end else if (out_valid) begin
        if (first_valid == 0) first_valid = k;
        if (stalled) begin
          tests++;
          if (out_addr !== held_addr || out_data !== held_data) begin
            fails++;
            $display("FAIL stall_hold: got %0d/%h, required %0d/%h", out_addr, out_data,
                     held_addr, held_data);
          end
        end
        out_ready = (ready_mode == 0) ? 1'b1 : ((k % 3) == 0);
        if (inject_at >= 0 && !injected && beats == inject_at) begin
          start = 1'b1;
          injected = 1;
        end
        if (out_ready) begin
          stalled = 0;
          last_acc = k;
          beats++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_beat: got %0d/%h, required no beat", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_addr, out_data} !== e) begin
              fails++;
              $display("FAIL beat: got %0d/%h, required %0d/%h", out_addr, out_data,
                       e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
            end
          end
        end else begin
          stalled = 1;
          held_addr = out_addr;
          held_data = out_data;
        end
      end
    end
    out_ready = 1'b1;
    tests++;
    if (!done_seen) begin
      fails++;
      $display("FAIL dump_timeout: no done within %0d cycles, required done", k);
    end
    tests++;
    if (beats != NR || reads != NR / 2 - 1) begin
      fails++;
      $display("FAIL beat_count: %0d beats %0d later reads, required %0d and %0d", beats,
               reads, NR, NR / 2 - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, out_valid} !== 3'b000 || out_addr !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy/done/valid=%b%b%b addr=%0d data=%h, required all 0",
               busy, done, out_valid, out_addr, out_data);
    end
    tests++;
    if (a1 !== '0 || a2 !== '0) begin
      fails++;
      $display("FAIL reset_addr: A1=%0d A2=%0d, required 0/0", a1, a2);
    end
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (checksum !== '0) begin
      fails++;
      $display("FAIL reset_checksum: got %h, required 0", checksum);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: busy=%b valid=%b, required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int fv;
    preload();
    start_dump();
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || a1 !== '0 || a2 !== AW'(1)) begin
      fails++;
      $display("FAIL first_read: busy=%b valid=%b A1=%0d A2=%0d, required 1/0/0/1", busy,
               out_valid, a1, a2);
    end
    collect(0, -1, fv);
    tests++;
    if (fv != 1) begin
      fails++;
      $display("FAIL first_valid: valid %0d cycles after READ, required 1", fv);
    end
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (checksum !== 32'h90) begin
      fails++;
      $display("FAIL checksum_basic: got %h, required 00000090", checksum);
    end
`endif
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL done_busy: busy=%b during done, required 0", busy);
    end
    @(negedge clk);
    tests++;
    if (a1 !== '0 || a2 !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL after_done: A1=%0d A2=%0d busy=%b done=%b, required 0/0/0/0", a1, a2,
               busy, done);
    end
  endtask

  task automatic test_backpressure();
    int fv;
    for (int i = 4; i < NR; i++) regs[i] = $urandom;
    start_dump();
    collect(1, -1, fv);
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (checksum !== exp_ck) begin
      fails++;
      $display("FAIL checksum_bp: got %h, required %h", checksum, exp_ck);
    end
`endif
    preload();
  endtask

  task automatic test_start_ignored();
    int fv;
    start_dump();
    collect(0, 4, fv);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL no_restart: busy=%b valid=%b after done, required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int fv;
    bit hit = 0;
    start_dump();
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (acc == 9) begin
          rst_n = 1'b0;
          hit = 1;
        end else begin
          acc++;
        end
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_timeout: 10th beat not seen, required within 200 cycles");
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_addr !== '0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b addr=%0d, required 0/0/0/0",
               out_valid, busy, done, out_addr);
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_done: done=%b busy=%b, required 0/0", done, busy);
    end
    start_dump();
    collect(0, -1, fv);
  endtask

  task automatic test_start_held();
    int fv;
    preload();
    @(negedge clk);
    start = 1'b1;
    push_dump();
    @(negedge clk);
    collect(0, -1, fv);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL held_idle: busy=%b valid=%b, required 0/0", busy, out_valid);
    end
    @(negedge clk);
    start = 1'b0;
    push_dump();
    tests++;
    if (busy !== 1'b1 || a1 !== '0 || a2 !== AW'(1)) begin
      fails++;
      $display("FAIL held_restart: busy=%b A1=%0d A2=%0d, required 1/0/1", busy, a1, a2);
    end
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (checksum !== '0) begin
      fails++;
      $display("FAIL checksum_clear: got %h, required 0", checksum);
    end
`endif
    collect(0, -1, fv);
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (checksum !== 32'h90) begin
      fails++;
      $display("FAIL checksum_held: got %h, required 00000090", checksum);
    end
`endif
  endtask

  initial begin
    preload();
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Sequential reader for the dual-read-port register file. On a start pulse it walks every register in pairs, using both read ports (A1/RD1, A2/RD2) in the same cycle. It then streams each register's address and value out over a valid/ready interface, one register per beat. It connects to the register file's read ports during debug/self-test and to a trace or UART sink on the output side.

## Interface
- XLEN, 32, data width of a register and of RD1/RD2
- AW, 5, register address width
- NREGS, 32, registers dumped; must be even and ≤ 2^AW

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle request to begin a dump; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- A1  out  AW  read address port 1 (even register of the current pair)
- A2  out  AW  read address port 2 (odd register of the current pair)
- RD1  in  XLEN  read data port 1, combinational from A1
- RD2  in  XLEN  read data port 2, combinational from A2
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts beat when high with out_valid
- out_addr  out  AW  register number of the current beat
- out_data  out  XLEN  register value of the current beat
- checksum  out  XLEN  running XOR of accepted beats (present only with DUMP_CHECKSUM_EN)

## Operation
- States: IDLE, READ, SEND0, SEND1, DONE. ptr is an AW-bit pair base; buf0 and buf1 are XLEN capture registers.
- IDLE: A1=0, A2=0, out_valid=0.
  - start=1 → ptr=0, go to READ.
- READ (1 cycle): A1=ptr, A2=ptr+1.
  - At the clock edge, buf0←RD1 and buf1←RD2, then go to SEND0.
- SEND0: out_valid=1, out_addr=ptr, out_data=buf0.
  - out_ready=1 → go to SEND1; otherwise hold.
- SEND1: out_valid=1, out_addr=ptr+1, out_data=buf1.
  - On out_ready=1: if ptr+2==NREGS → go to DONE; otherwise ptr←ptr+2 and go to READ.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
  - A start presented in DONE is ignored.
- busy=1 in READ, SEND0 and SEND1.
- Register x0 is dumped like any other register; the dumper does no special casing.
- Register-file writes during a dump: each pair is a snapshot taken at its READ edge. There is no coherence across pairs.

## Timing
- Reset values: state=IDLE, ptr=0, buf0=buf1=0, busy=0, done=0, out_valid=0, out_addr=0, out_data=0, A1=0, A2=0, checksum=0.
- start sampled in cycle t → READ in t+1 → first out_valid in t+2.
- Each pair takes 3 cycles with out_ready tied high. With NREGS=32 that is 48 cycles from READ entry to the last beat, and done follows 1 cycle after the last acceptance.
- While out_valid=1 and out_ready=0, out_addr and out_data hold stable; out_valid never drops without acceptance.
- out_valid is low during READ. This gap is intentional, so no combinational path exists from RD1/RD2 to out_data.
- Reset asserted mid-dump: on the next edge, return to IDLE with all outputs at reset values. No done pulse is emitted.
- start while busy: ignored, with no restart and no effect on ptr.
- start held high continuously: a new dump begins in the cycle after DONE.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - checksum port exists and is cleared to 0 when start is accepted.
  - checksum ← checksum ^ out_data on every accepted beat.
  - The value is final and stable when done pulses, and holds until the next accepted start.
- DUMP_CHECKSUM_EN undefined: the checksum port and its register are absent. All other behaviour is identical.

## Test plan
- Preload x0..x3 = 0xAC, 0xF0, 0x0F, 0xC3 and the rest zero; pulse start with out_ready=1.
  - Expect beats (0,0xAC), (1,0xF0), (2,0x0F), (3,0xC3), then (4..31, 0).
  - First out_valid 2 cycles after start; done 1 cycle after the beat for addr 31.
- Backpressure: toggle out_ready 1-of-3 cycles.
  - Same beat sequence; out_addr and out_data stable while stalled; no beat dropped or duplicated.
- A1/A2 check: during each READ, A1 is even and A2=A1+1, covering pairs 0/1 through 30/31.
  - A1=A2=0 when idle.
- Pulse start again at the 5th beat.
  - Ignored; the dump completes normally with exactly 32 beats.
- Assert rst_n=0 for 1 cycle at the 10th beat.
  - Next cycle: out_valid=0, busy=0, no done. A subsequent start dumps from addr 0.
- With DUMP_CHECKSUM_EN and the preload above:
  - checksum = 0xAC^0xF0^0x0F^0xC3 = 0x90 at done.
  - checksum cleared to 0 on the next start.
